decode_cycle: RTL and testbench

Decode stage of the 5-stage RISC-V (RV32I subset) pipeline. It consumes the fetch stage's registered outputs (InstrD, PCD, PCPlus4D) and the writeback-stage register write port. It contains the 32x32 register file, the main/ALU control decoder and the immediate extender. Results are registered into the D/E pipeline register that feeds the execute stage.

---
 rtl/decode_cycle_if.sv | 39 +++
 rtl/decode_cycle.sv | 179 +++++++++++++++++
 tb/tb_decode_cycle.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_cycle_if.sv
// Decode-stage bus: fetch inputs, writeback port and flush in; D/E pipeline register out.
// The decode stage is the slave. The surrounding pipeline (or a bench) is the master.
interface decode_cycle_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;

    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
        input  RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
        output RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
    );
endinterface

// File: rtl/decode_cycle.sv
// RV32I-subset decode stage: register file with write-through bypass, control decoder,
// immediate extender and the D/E pipeline register.
module decode_cycle #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_cycle_if.slave bus
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmJ} immSel_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode   = bus.InstrD[6:0];
    assign funct3   = bus.InstrD[14:12];
    assign funct7b5 = bus.InstrD[30];
    assign rs1      = bus.InstrD[19:15];
    assign rs2      = bus.InstrD[24:20];
    assign rd       = bus.InstrD[11:7];

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (bus.RegWriteW && bus.RDW != 5'd0) begin
            regs[bus.RDW] <= bus.ResultW;
        end
    end

    // A same-cycle writeback wins over the stored copy, so the D/E register never holds stale data.
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) rd1 = (bus.RegWriteW && bus.RDW == rs1) ? bus.ResultW : regs[rs1];
        if (rs2 != 5'd0) rd2 = (bus.RegWriteW && bus.RDW == rs2) ? bus.ResultW : regs[rs2];
    end

    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic [2:0] aluControl;
    logic       aluSrc;
    immSel_t    immSel;
    logic [2:0] aluFromFunct3;
    logic       funct3Ok;

    // Shared ALU mapping for R-type and I-ALU; only R-type honours the sub bit.
    always_comb begin
        aluFromFunct3 = 3'b000;
        funct3Ok      = 1'b1;
        case (funct3)
            3'b000:  aluFromFunct3 = (opcode == OpRType && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  aluFromFunct3 = 3'b101;
            3'b110:  aluFromFunct3 = 3'b011;
            3'b111:  aluFromFunct3 = 3'b010;
            default: funct3Ok      = 1'b0;
        endcase
    end

    always_comb begin
        regWrite   = 1'b0;
        resultSrc  = 2'b00;
        memWrite   = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        aluControl = 3'b000;
        aluSrc     = 1'b0;
        immSel     = ImmNone;
        case (opcode)
            OpLoad: if (funct3 == 3'b010) begin
                regWrite  = 1'b1;
                resultSrc = 2'b01;
                aluSrc    = 1'b1;
                immSel    = ImmI;
            end
            OpStore: if (funct3 == 3'b010) begin
                memWrite = 1'b1;
                aluSrc   = 1'b1;
                immSel   = ImmS;
            end
            OpRType: if (funct3Ok) begin
                regWrite   = 1'b1;
                aluControl = aluFromFunct3;
            end
            OpIAlu: if (funct3Ok) begin
                regWrite   = 1'b1;
                aluSrc     = 1'b1;
                aluControl = aluFromFunct3;
                immSel     = ImmI;
            end
            OpBranch: if (funct3 == 3'b000) begin
                branch     = 1'b1;
                aluControl = 3'b001;
                immSel     = ImmB;
            end
            OpJal: begin
                regWrite  = 1'b1;
                jump      = 1'b1;
                resultSrc = 2'b10;
                immSel    = ImmJ;
            end
            default: ;
        endcase
    end

    logic [DATA_W-1:0] immExt;
    logic [31:0]       instr;

    assign instr = bus.InstrD;

    always_comb begin
        immExt = '0;
        case (immSel)
            ImmI:    immExt = {{20{instr[31]}}, instr[31:20]};
            ImmS:    immExt = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    immExt = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmJ:    immExt = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: immExt = '0;
        endcase
    end

    // Reset dominates flush; both turn the D/E register into a bubble.
    always_ff @(posedge clk) begin
        if (!rst || bus.FlushE) begin
            bus.RegWriteE   <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.MemWriteE   <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUControlE <= 3'b000;
            bus.ALUSrcE     <= 1'b0;
            bus.RD1E        <= '0;
            bus.RD2E        <= '0;
            bus.ImmExtE     <= '0;
            bus.Rs1E        <= '0;
            bus.Rs2E        <= '0;
            bus.RdE         <= '0;
            bus.PCE         <= '0;
            bus.PCPlus4E    <= '0;
        end else begin
            bus.RegWriteE   <= regWrite;
            bus.ResultSrcE  <= resultSrc;
            bus.MemWriteE   <= memWrite;
            bus.JumpE       <= jump;
            bus.BranchE     <= branch;
            bus.ALUControlE <= aluControl;
            bus.ALUSrcE     <= aluSrc;
            bus.RD1E        <= rd1;
            bus.RD2E        <= rd2;
            bus.ImmExtE     <= immExt;
            bus.Rs1E        <= rs1;
            bus.Rs2E        <= rs2;
            bus.RdE         <= rd;
            bus.PCE         <= bus.PCD;
            bus.PCPlus4E    <= bus.PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: each task drives a scenario and checks the D/E outputs
// one cycle after the inputs were applied.
module tb_decode_cycle;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decode_cycle_if bus ();

    decode_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]   ctrlE;
    logic [184:0] allE;

    assign ctrlE = {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
                    bus.ALUControlE, bus.ALUSrcE};
    assign allE  = {ctrlE, bus.RD1E, bus.RD2E, bus.ImmExtE, bus.Rs1E, bus.Rs2E, bus.RdE,
                    bus.PCE, bus.PCPlus4E};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bus.InstrD   = instr;
        bus.PCD      = pc;
        bus.PCPlus4D = pc + 32'd4;
    endtask

    task automatic writeback(input logic we, input logic [4:0] rdw, input logic [31:0] data);
        bus.RegWriteW = we;
        bus.RDW       = rdw;
        bus.ResultW   = data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.FlushE = 1'b0;
        writeback(1'b0, 5'd0, 32'd0);
        drive(32'h00500093, 32'h10);
        tick();
        tick();
        checks++;
        if (allE !== '0) begin
            errors++;
            $display("FAIL reset_all_zero got %h want 0", allE);
        end
    endtask

    task automatic test_addi();
        rst = 1'b1;
        drive(32'h00500093, 32'h10);
        writeback(1'b1, 5'd1, 32'd5);
        tick();
        checks++;
        if (ctrlE !== 10'b1_00_0_0_0_000_1) begin
            errors++;
            $display("FAIL addi_ctrl got %b want %b", ctrlE, 10'b1_00_0_0_0_000_1);
        end
        checks++;
        if (bus.ImmExtE !== 32'd5 || bus.RdE !== 5'd1 || bus.RD1E !== 32'd0) begin
            errors++;
            $display("FAIL addi_fields got imm=%h rd=%0d rd1=%h want imm=5 rd=1 rd1=0",
                     bus.ImmExtE, bus.RdE, bus.RD1E);
        end
        checks++;
        if (bus.PCE !== 32'h10 || bus.PCPlus4E !== 32'h14) begin
            errors++;
            $display("FAIL addi_pc got pc=%h pc4=%h want 10/14", bus.PCE, bus.PCPlus4E);
        end
        writeback(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_x0_write();
        drive(32'h00528333, 32'h14);
        writeback(1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        checks++;
        if (bus.RD1E !== 32'd0 || bus.RD2E !== 32'd0 || bus.RdE !== 5'd6) begin
            errors++;
            $display("FAIL x0_bypass got rd1=%h rd2=%h rd=%0d want 0/0/6", bus.RD1E, bus.RD2E, bus.RdE);
        end
        writeback(1'b0, 5'd0, 32'd0);
        drive(32'h00000333, 32'h18);
        tick();
        checks++;
        if (bus.RD1E !== 32'd0 || bus.RD2E !== 32'd0) begin
            errors++;
            $display("FAIL x0_read got rd1=%h rd2=%h want 0/0", bus.RD1E, bus.RD2E);
        end
    endtask

    task automatic test_bypass();
        drive(32'h00528333, 32'h1C);
        writeback(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        checks++;
        if (bus.RD1E !== 32'hDEADBEEF || bus.RD2E !== 32'hDEADBEEF || bus.RdE !== 5'd6) begin
            errors++;
            $display("FAIL bypass got rd1=%h rd2=%h rd=%0d want deadbeef/deadbeef/6",
                     bus.RD1E, bus.RD2E, bus.RdE);
        end
        checks++;
        if (ctrlE !== 10'b1_00_0_0_0_000_0 || bus.ImmExtE !== 32'd0) begin
            errors++;
            $display("FAIL add_ctrl got ctrl=%b imm=%h want %b/0", ctrlE, bus.ImmExtE, 10'b1_00_0_0_0_000_0);
        end
        writeback(1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if (bus.RD1E !== 32'hDEADBEEF || bus.RD2E !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL stored_x5 got rd1=%h rd2=%h want deadbeef", bus.RD1E, bus.RD2E);
        end
    endtask

    task automatic test_branch_store();
        drive(32'hFE208CE3, 32'h40);
        tick();
        checks++;
        if (ctrlE !== 10'b0_00_0_0_1_001_0 || bus.ImmExtE !== 32'hFFFFFFF8) begin
            errors++;
            $display("FAIL beq got ctrl=%b imm=%h want %b/fffffff8", ctrlE, bus.ImmExtE, 10'b0_00_0_0_1_001_0);
        end
        checks++;
        if (bus.Rs1E !== 5'd1 || bus.Rs2E !== 5'd2 || bus.RD1E !== 32'd5) begin
            errors++;
            $display("FAIL beq_regs got rs1=%0d rs2=%0d rd1=%h want 1/2/5", bus.Rs1E, bus.Rs2E, bus.RD1E);
        end
        drive(32'h0020A623, 32'h44);
        tick();
        checks++;
        if (ctrlE !== 10'b0_00_1_0_0_000_1 || bus.ImmExtE !== 32'h0000000C) begin
            errors++;
            $display("FAIL sw got ctrl=%b imm=%h want %b/c", ctrlE, bus.ImmExtE, 10'b0_00_1_0_0_000_1);
        end
    endtask

    task automatic test_alu_ops();
        drive(32'h40208433, 32'h50);
        tick();
        checks++;
        if (bus.ALUControlE !== 3'b001 || bus.RegWriteE !== 1'b1) begin
            errors++;
            $display("FAIL sub got alu=%b rw=%b want 001/1", bus.ALUControlE, bus.RegWriteE);
        end
        drive(32'hFFF0F493, 32'h54);
        tick();
        checks++;
        if (bus.ALUControlE !== 3'b010 || bus.ImmExtE !== 32'hFFFFFFFF || bus.ALUSrcE !== 1'b1) begin
            errors++;
            $display("FAIL andi got alu=%b imm=%h src=%b want 010/ffffffff/1",
                     bus.ALUControlE, bus.ImmExtE, bus.ALUSrcE);
        end
        drive(32'h00202013, 32'h58);
        tick();
        checks++;
        if (bus.ALUControlE !== 3'b101 || bus.ImmExtE !== 32'd2) begin
            errors++;
            $display("FAIL slti got alu=%b imm=%h want 101/2", bus.ALUControlE, bus.ImmExtE);
        end
        drive(32'h00A0E033, 32'h5C);
        tick();
        checks++;
        if (bus.ALUControlE !== 3'b011 || bus.ALUSrcE !== 1'b0) begin
            errors++;
            $display("FAIL or got alu=%b src=%b want 011/0", bus.ALUControlE, bus.ALUSrcE);
        end
        drive(32'h40000093, 32'h60);
        tick();
        checks++;
        if (bus.ALUControlE !== 3'b000 || bus.ImmExtE !== 32'h00000400) begin
            errors++;
            $display("FAIL addi_f7 got alu=%b imm=%h want 000/400", bus.ALUControlE, bus.ImmExtE);
        end
        drive(32'h00001033, 32'h64);
        tick();
        checks++;
        if (ctrlE !== 10'd0 || bus.ImmExtE !== 32'd0) begin
            errors++;
            $display("FAIL bad_funct3 got ctrl=%b imm=%h want 0/0", ctrlE, bus.ImmExtE);
        end
    endtask

    task automatic test_jal();
        drive(32'h008000EF, 32'h70);
        tick();
        checks++;
        if (ctrlE !== 10'b1_10_0_1_0_000_0 || bus.ImmExtE !== 32'd8 || bus.PCPlus4E !== 32'h74) begin
            errors++;
            $display("FAIL jal got ctrl=%b imm=%h pc4=%h want %b/8/74",
                     ctrlE, bus.ImmExtE, bus.PCPlus4E, 10'b1_10_0_1_0_000_0);
        end
    endtask

    task automatic test_flush();
        drive(32'h0040A203, 32'h80);
        bus.FlushE = 1'b1;
        writeback(1'b1, 5'd3, 32'hCAFE0003);
        tick();
        checks++;
        if (allE !== '0) begin
            errors++;
            $display("FAIL flush_bubble got %h want 0", allE);
        end
        bus.FlushE = 1'b0;
        writeback(1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if (ctrlE !== 10'b1_01_0_0_0_000_1 || bus.ImmExtE !== 32'd4 || bus.RdE !== 5'd4 || bus.RD1E !== 32'd5) begin
            errors++;
            $display("FAIL lw got ctrl=%b imm=%h rd=%0d rd1=%h want %b/4/4/5",
                     ctrlE, bus.ImmExtE, bus.RdE, bus.RD1E, 10'b1_01_0_0_0_000_1);
        end
        drive(32'h000183B3, 32'h84);
        tick();
        checks++;
        if (bus.RD1E !== 32'hCAFE0003) begin
            errors++;
            $display("FAIL flush_write_kept got rd1=%h want cafe0003", bus.RD1E);
        end
    endtask

    task automatic test_illegal();
        drive(32'hFFFFFFFF, 32'h90);
        tick();
        checks++;
        if (ctrlE !== 10'd0 || bus.ImmExtE !== 32'd0) begin
            errors++;
            $display("FAIL illegal_ctrl got ctrl=%b imm=%h want 0/0", ctrlE, bus.ImmExtE);
        end
        checks++;
        if (bus.RdE !== 5'd31 || bus.Rs1E !== 5'd31 || bus.Rs2E !== 5'd31 || bus.PCE !== 32'h90) begin
            errors++;
            $display("FAIL illegal_fields got rd=%0d rs1=%0d rs2=%0d pc=%h want 31/31/31/90",
                     bus.RdE, bus.Rs1E, bus.Rs2E, bus.PCE);
        end
    endtask

    task automatic test_reset_midflight();
        drive(32'h00308533, 32'hA0);
        bus.FlushE = 1'b1;
        writeback(1'b1, 5'd1, 32'h11111111);
        rst = 1'b0;
        tick();
        checks++;
        if (allE !== '0) begin
            errors++;
            $display("FAIL reset_midflight got %h want 0", allE);
        end
        rst = 1'b1;
        bus.FlushE = 1'b0;
        writeback(1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if (bus.RD1E !== 32'd0 || bus.RD2E !== 32'd0 || bus.RdE !== 5'd10 || bus.RegWriteE !== 1'b1) begin
            errors++;
            $display("FAIL regs_cleared got rd1=%h rd2=%h rd=%0d rw=%b want 0/0/10/1",
                     bus.RD1E, bus.RD2E, bus.RdE, bus.RegWriteE);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.FlushE = 1'b0;
        drive(32'd0, 32'd0);
        writeback(1'b0, 5'd0, 32'd0);
        test_reset();
        test_addi();
        test_x0_write();
        test_bypass();
        test_branch_store();
        test_alu_ops();
        test_jal();
        test_flush();
        test_illegal();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
